collision_probe: RTL and testbench

- Produces the four blocked flags (left/right/up/down) that the character movement stage consumes.
- Once per frame tick it samples the character position and scroll offset, then scans 8 probe points around the character sprite against the tile-map RAM with a pipelined read sequence.
- At the end of the scan it updates all flags atomically.
- Sits between the tile-map RAM and the character movement block.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/probe_addr_gen.sv | 67 ++++++
 rtl/collision_probe.sv | 142 ++++++++++++++
 tb/tb_collision_probe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, probe indices and FSM encoding for the collision probe.
// Imported by collision_probe and probe_addr_gen.
package game_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int TILE_SHIFT  = 3;
    localparam int MAP_ROWS    = 15;
    localparam int COL_BITS    = 7;
    localparam int ROW_BITS    = 4;
    localparam int ADDR_W      = ROW_BITS + COL_BITS;
    localparam int POS_W       = 8;
    localparam int SCROLL_W    = 10;
    localparam int CALC_W      = 10;
    localparam int TILE_W      = 4;
    localparam int NUM_PROBES  = 8;
    localparam int PROBE_IDX_W = 3;

    localparam logic [TILE_W-1:0] TILE_EMPTY = 4'd0;

    localparam logic [PROBE_IDX_W-1:0] PROBE_DOWN0  = 3'd0;
    localparam logic [PROBE_IDX_W-1:0] PROBE_DOWN1  = 3'd1;
    localparam logic [PROBE_IDX_W-1:0] PROBE_UP0    = 3'd2;
    localparam logic [PROBE_IDX_W-1:0] PROBE_UP1    = 3'd3;
    localparam logic [PROBE_IDX_W-1:0] PROBE_LEFT0  = 3'd4;
    localparam logic [PROBE_IDX_W-1:0] PROBE_LEFT1  = 3'd5;
    localparam logic [PROBE_IDX_W-1:0] PROBE_RIGHT0 = 3'd6;
    localparam logic [PROBE_IDX_W-1:0] PROBE_RIGHT1 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Each direction owns two adjacent probe slots; the flag is their OR.
    function automatic logic pair_hit(input logic [NUM_PROBES-1:0] res,
                                      input logic [PROBE_IDX_W-1:0] first);
        return res[first] | res[first + 3'd1];
    endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// Combinational tile address and off-map decode for one probe point
// around the latched character position.
module probe_addr_gen
    import game_pkg::*;
(
    input  logic [POS_W-1:0]       x_i,
    input  logic [POS_W-1:0]       y_i,
    input  logic [SCROLL_W-1:0]    scroll_i,
    input  logic [PROBE_IDX_W-1:0] probe_i,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   off_map_o
);

    logic [CALC_W-1:0]   px_s;
    logic [CALC_W-1:0]   py_s;
    logic [CALC_W-1:0]   row_full_s;
    logic [COL_BITS-1:0] col_s;
    logic                up_s;

    // Probe offset selection, 10-bit wrapping arithmetic, then tile indexing.
    always_comb begin
        px_s = CALC_W'(x_i);
        py_s = CALC_W'(y_i);
        up_s = 1'b0;
        case (probe_i)
            PROBE_DOWN0: begin
                py_s = CALC_W'(y_i) + CALC_W'(CHAR_H);
            end
            PROBE_DOWN1: begin
                px_s = CALC_W'(x_i) + CALC_W'(CHAR_W - 1);
                py_s = CALC_W'(y_i) + CALC_W'(CHAR_H);
            end
            PROBE_UP0: begin
                py_s = CALC_W'(y_i) - CALC_W'(1);
                up_s = 1'b1;
            end
            PROBE_UP1: begin
                px_s = CALC_W'(x_i) + CALC_W'(CHAR_W - 1);
                py_s = CALC_W'(y_i) - CALC_W'(1);
                up_s = 1'b1;
            end
            PROBE_LEFT0: begin
                px_s = CALC_W'(x_i) - CALC_W'(1);
            end
            PROBE_LEFT1: begin
                px_s = CALC_W'(x_i) - CALC_W'(1);
                py_s = CALC_W'(y_i) + CALC_W'(CHAR_H - 1);
            end
            PROBE_RIGHT0: begin
                px_s = CALC_W'(x_i) + CALC_W'(CHAR_W);
            end
            PROBE_RIGHT1: begin
                px_s = CALC_W'(x_i) + CALC_W'(CHAR_W);
                py_s = CALC_W'(y_i) + CALC_W'(CHAR_H - 1);
            end
            default: begin
                up_s = 1'b0;
            end
        endcase
        col_s      = COL_BITS'((scroll_i + px_s) >> TILE_SHIFT);
        row_full_s = py_s >> TILE_SHIFT;
        // The full 10-bit row is compared so rows beyond the RAM never alias.
        off_map_o  = (row_full_s >= CALC_W'(MAP_ROWS)) || (up_s && (y_i == 8'd0));
        addr_o     = {row_full_s[ROW_BITS-1:0], col_s};
    end

endmodule

// File: rtl/collision_probe.sv
// Per-frame 8-point collision scan against the tile-map RAM; produces the
// four blocked flags, updated together with a one-cycle scan_done pulse.
module collision_probe
    import game_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    input  logic [POS_W-1:0]    x_position,
    input  logic [POS_W-1:0]    y_position,
    input  logic [SCROLL_W-1:0] scroll_x,
    output logic [ADDR_W-1:0]   map_addr,
    output logic                map_rd,
    input  logic [TILE_W-1:0]   map_data,
    output logic                left_blocked,
    output logic                right_blocked,
    output logic                up_blocked,
    output logic                down_blocked,
    output logic                scan_done
);

    state_t                  state_q, state_d;
    logic [PROBE_IDX_W-1:0]  idx_q, idx_d;
    logic [POS_W-1:0]        x_q, x_d;
    logic [POS_W-1:0]        y_q, y_d;
    logic [SCROLL_W-1:0]     scroll_q, scroll_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic                    off_q;
    logic                    rd_dly_q;
    logic [PROBE_IDX_W-1:0]  pidx_q;
    logic                    poff_q;
    logic [NUM_PROBES-1:0]   result_q;
    logic [3:0]              flags_q;
    logic                    done_q;
    logic [ADDR_W-1:0]       gen_addr_s;
    logic                    gen_off_s;

    // Address is generated from next-state values so map_addr/map_rd can be registered.
    probe_addr_gen u_addr_gen (
        .x_i       (x_d),
        .y_i       (y_d),
        .scroll_i  (scroll_d),
        .probe_i   (idx_d),
        .addr_o    (gen_addr_s),
        .off_map_o (gen_off_s)
    );

    // Next-state logic: FSM, probe index and position latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        y_d      = y_q;
        scroll_d = scroll_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_SCAN;
                    idx_d    = 3'd0;
                    x_d      = x_position;
                    y_d      = y_position;
                    scroll_d = scroll_x;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_q == 3'(NUM_PROBES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        rd_d = (state_d == ST_SCAN);
        if (rd_d) begin
            addr_d = gen_addr_s;
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
    end

    // State, read pipeline, result shadow and atomic flag update.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            x_q      <= 8'd0;
            y_q      <= 8'd0;
            scroll_q <= 10'd0;
            addr_q   <= {ADDR_W{1'b0}};
            rd_q     <= 1'b0;
            off_q    <= 1'b0;
            rd_dly_q <= 1'b0;
            pidx_q   <= 3'd0;
            poff_q   <= 1'b0;
            result_q <= 8'd0;
            flags_q  <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            scroll_q <= scroll_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            off_q    <= gen_off_s;
            rd_dly_q <= rd_q;
            pidx_q   <= idx_q;
            poff_q   <= off_q;
            // RAM data belongs to the probe issued one cycle earlier.
            if (rd_dly_q) begin
                result_q[pidx_q] <= poff_q ? 1'b0 : (map_data != TILE_EMPTY);
            end else begin
                result_q <= result_q;
            end
            if (state_q == ST_DONE) begin
                flags_q <= {pair_hit(result_q, PROBE_LEFT0),
                            pair_hit(result_q, PROBE_RIGHT0),
                            pair_hit(result_q, PROBE_UP0),
                            pair_hit(result_q, PROBE_DOWN0)};
            end else begin
                flags_q <= flags_q;
            end
            done_q <= (state_q == ST_DONE);
        end
    end

    assign map_addr      = addr_q;
    assign map_rd        = rd_q;
    assign left_blocked  = flags_q[3];
    assign right_blocked = flags_q[2];
    assign up_blocked    = flags_q[1];
    assign down_blocked  = flags_q[0];
    assign scan_done     = done_q;

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe: tile RAM model with 1-cycle read latency,
// a vector table of scans plus hand sequences for the multi-cycle corners.
module tb_collision_probe;

    logic        clock;
    logic        resetn;
    logic        enable;
    logic [7:0]  x_position;
    logic [7:0]  y_position;
    logic [9:0]  scroll_x;
    logic [10:0] map_addr;
    logic        map_rd;
    logic [3:0]  map_data = 4'd0;
    logic        left_blocked, right_blocked, up_blocked, down_blocked, scan_done;
    logic [3:0]  flags_s;

    logic [3:0]  ram [0:2047];

    int checks = 0;
    int errors = 0;
    logic [3:0] prev_flags;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [9:0] sc;
        int         r0;
        int         c0;
        int         r1;
        int         c1;
        logic [3:0] exp;   // {left, right, up, down}
    } vec_t;

    vec_t vecs [9];

    collision_probe dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .x_position    (x_position),
        .y_position    (y_position),
        .scroll_x      (scroll_x),
        .map_addr      (map_addr),
        .map_rd        (map_rd),
        .map_data      (map_data),
        .left_blocked  (left_blocked),
        .right_blocked (right_blocked),
        .up_blocked    (up_blocked),
        .down_blocked  (down_blocked),
        .scan_done     (scan_done)
    );

    assign flags_s = {left_blocked, right_blocked, up_blocked, down_blocked};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (map_rd) map_data <= ram[map_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ram();
        for (int k = 0; k < 2048; k++) ram[k] = 4'd0;
    endtask

    // c < 0 fills the whole row; r < 0 places nothing.
    task automatic put_tile(input int r, input int c);
        if (r >= 0) begin
            if (c < 0) begin
                for (int k = 0; k < 128; k++) ram[r * 128 + k] = 4'd5;
            end else begin
                ram[r * 128 + c] = 4'd5;
            end
        end
    endtask

    // Cycle 0 = enable cycle; returns the cycle scan_done is seen (-1 on timeout).
    task automatic run_scan(input logic [7:0] x, input logic [7:0] y, input logic [9:0] sc,
                            output int lat, output int rds);
        @(negedge clock);
        x_position = x;
        y_position = y;
        scroll_x   = sc;
        enable     = 1'b1;
        lat = -1;
        rds = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) enable = 1'b0;
            if (map_rd) rds++;
            if (c == 5) check("flags_hold_midscan", 32'(flags_s), 32'(prev_flags));
            if (scan_done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, rds, dones, first_done, last_done, pulses, rd_cnt;

        vecs[0] = '{8'd72, 8'd96,  10'd0,    14, -1,  -1,  0, 4'b0001}; // floor
        vecs[1] = '{8'd72, 8'd0,   10'd0,     0,  9,  15,  9, 4'b0000}; // y=0 ceiling off-map
        vecs[2] = '{8'd72, 8'd24,  10'd0,     2,  9,  -1,  0, 4'b0010}; // ceiling row 2
        vecs[3] = '{8'd72, 8'd96,  10'd1016, 12,  7,  -1,  0, 4'b1000}; // scroll wrap, left wall
        vecs[4] = '{8'd72, 8'd96,  10'd0,    13, 10,  -1,  0, 4'b0100}; // right wall
        vecs[5] = '{8'd72, 8'd112, 10'd0,     0,  9,  15,  8, 4'b0000}; // rows >= 15 masked
        vecs[6] = '{8'd77, 8'd96,  10'd0,    14, 10,  -1,  0, 4'b0001}; // down via x+7 only
        vecs[7] = '{8'd0,  8'd96,  10'd0,    13, 127, -1,  0, 4'b1000}; // x-1 wraps to col 127
        vecs[8] = '{8'd72, 8'd96,  10'd0,    11,  9,  12, 10, 4'b0110}; // up + right

        resetn     = 1'b0;
        enable     = 1'b0;
        x_position = 8'd0;
        y_position = 8'd0;
        scroll_x   = 10'd0;
        clear_ram();
        repeat (3) @(negedge clock);
        check("reset_flags", 32'(flags_s), 32'd0);
        check("reset_done", 32'(scan_done), 32'd0);
        check("reset_rd", 32'(map_rd), 32'd0);
        check("reset_addr", 32'(map_addr), 32'd0);
        resetn = 1'b1;
        prev_flags = 4'd0;

        for (int v = 0; v < 9; v++) begin
            clear_ram();
            put_tile(vecs[v].r0, vecs[v].c0);
            put_tile(vecs[v].r1, vecs[v].c1);
            run_scan(vecs[v].x, vecs[v].y, vecs[v].sc, lat, rds);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd11);
            check($sformatf("vec%0d_reads", v), 32'(rds), 32'd8);
            check($sformatf("vec%0d_flags", v), 32'(flags_s), 32'(vecs[v].exp));
            @(negedge clock);
            check($sformatf("vec%0d_done_pulse", v), 32'(scan_done), 32'd0);
            prev_flags = vecs[v].exp;
        end

        // Inputs change mid-scan and a second enable arrives while busy.
        clear_ram();
        put_tile(14, -1);
        @(negedge clock);
        x_position = 8'd72;
        y_position = 8'd96;
        scroll_x   = 10'd0;
        enable     = 1'b1;
        dones = 0;
        first_done = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 1) enable = 1'b0;
            if (c == 3) y_position = 8'd0;
            if (c == 5) enable = 1'b1;
            if (c == 6) enable = 1'b0;
            if (scan_done) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
        end
        check("midscan_done_count", 32'(dones), 32'd1);
        check("midscan_done_cycle", 32'(first_done), 32'd11);
        check("midscan_flags", 32'(flags_s), 32'b0001);
        y_position = 8'd96;

        // Reset in the middle of a scan aborts it.
        @(negedge clock);
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) enable = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("rst_mid_flags", 32'(flags_s), 32'd0);
        check("rst_mid_rd", 32'(map_rd), 32'd0);
        check("rst_mid_done", 32'(scan_done), 32'd0);
        check("rst_mid_addr", 32'(map_addr), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        dones = 0;
        rds = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (scan_done) dones++;
            if (map_rd) rds++;
        end
        check("post_rst_no_done", 32'(dones), 32'd0);
        check("post_rst_no_rd", 32'(rds), 32'd0);
        prev_flags = 4'd0;

        run_scan(8'd72, 8'd96, 10'd0, lat, rds);
        check("rescan_latency", 32'(lat), 32'd11);
        check("rescan_flags", 32'(flags_s), 32'b0001);
        prev_flags = 4'b0001;

        // enable held high for 40 cycles: back-to-back scans.
        @(negedge clock);
        enable = 1'b1;
        pulses = 0;
        last_done = 0;
        rd_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 40) enable = 1'b0;
            if (map_rd) rd_cnt++;
            if (scan_done) begin
                pulses++;
                check("b2b_period", 32'(c - last_done), 32'd11);
                check("b2b_reads_per_scan", 32'(rd_cnt), 32'd8);
                last_done = c;
                rd_cnt = 0;
            end
        end
        check("b2b_pulse_count", 32'(pulses), 32'd4);
        check("b2b_trailing_reads", 32'(rd_cnt), 32'd0);
        check("b2b_flags", 32'(flags_s), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
